// File: rtl/paicore_recv_merge_2c.sv
// rtl/paicore_recv_merge_2c.sv - two-channel req/ack receiver packing 32-bit word pairs onto one round-robin AXI4-Stream master
module paicore_recv_merge_2c #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        rx_enable,
  input  logic [31:0] recv_len,
  output logic [31:0] data_cnt,
  output logic [31:0] tlast_cnt,
  input  logic        request_C0,
  input  logic [31:0] din_C0,
  output logic        acknowledge_C0,
  input  logic        request_C1,
  input  logic [31:0] din_C1,
  output logic        acknowledge_C1,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  output logic        o_rx_done
);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} ch_state_t;

  logic [1:0]  w_req;
  logic [31:0] w_din [2];
  logic [1:0]  w_pend;
  logic [63:0] w_pack [2];
  logic [1:0]  w_ack;
  logic [1:0]  w_grant;
  logic        w_load;
  logic        w_accept;
  logic [31:0] w_cnt_next;
  logic        w_last_new;

  logic        r_tvalid;
  logic [63:0] r_tdata;
  logic        r_tlast;
  logic        r_ptr;
  logic [31:0] r_beat_cnt;
  logic [31:0] r_data_cnt;
  logic [31:0] r_tlast_cnt;
  logic        r_done;

  assign w_req    = {request_C1, request_C0};
  assign w_din[0] = din_C0;
  assign w_din[1] = din_C1;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SS-1:0] r_sync;
    ch_state_t     r_state;
    logic          r_ack;
    logic          r_half;
    logic          r_pend;
    logic [63:0]   r_pack;
    logic [TW-1:0] r_timer;
    logic          w_cap;

    // A full pack register withholds the ack, which stalls the sending core.
    assign w_cap    = (r_state == ST_IDLE) && r_sync[SS-1] && rx_enable && !r_pend;
    assign w_pend[g] = r_pend;
    assign w_pack[g] = r_pack;
    assign w_ack[g]  = r_ack;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
        r_sync  <= '0;
        r_state <= ST_IDLE;
        r_ack   <= 1'b0;
        r_half  <= 1'b0;
        r_pend  <= 1'b0;
        r_pack  <= '0;
        r_timer <= '0;
      end else begin
        r_sync <= {r_sync[SS-2:0], w_req[g]};
        if (r_state == ST_IDLE) begin
          if (w_cap) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
        end else if (!r_sync[SS-1]) begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end

        if (w_cap) begin
          r_timer <= '0;
          if (r_half) begin
            r_pack[63:32] <= w_din[g];
            r_pend        <= 1'b1;
          end else begin
            r_pack[31:0] <= w_din[g];
            r_half       <= 1'b1;
          end
        end else if (w_grant[g]) begin
          r_pend  <= 1'b0;
          r_half  <= 1'b0;
          r_timer <= '0;
        end else if (r_half && !r_pend && (IDLE_TIMEOUT != 0)) begin
          if (r_timer == TW'(IDLE_TIMEOUT - 1)) begin
            r_pack[63:32] <= '0;
            r_pend        <= 1'b1;
            r_timer       <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
      end
    end
  end

  assign w_load   = !r_tvalid || m_axis_tready;
  assign w_accept = r_tvalid && m_axis_tready;

  always_comb begin
    w_grant = 2'b00;
    if (w_load) begin
      if (w_pend == 2'b11) w_grant = r_ptr ? 2'b10 : 2'b01;
      else                 w_grant = w_pend;
    end
  end

  // Frame position as it will stand after this edge's handshake, so a beat
  // loaded while its predecessor is being accepted gets the right tlast.
  assign w_cnt_next = w_accept ? (r_tlast ? 32'd0 : r_beat_cnt + 32'd1) : r_beat_cnt;
  assign w_last_new = (recv_len != 32'd0) && ((w_cnt_next + 32'd1) == recv_len);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_ptr       <= 1'b0;
      r_beat_cnt  <= '0;
      r_data_cnt  <= '0;
      r_tlast_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= w_accept && r_tlast;
      r_beat_cnt <= w_cnt_next;
      if (w_accept) begin
        r_data_cnt <= r_data_cnt + 32'd1;
        if (r_tlast) r_tlast_cnt <= r_tlast_cnt + 32'd1;
      end
      if (w_load) begin
        r_tvalid <= |w_grant;
        r_tlast  <= (|w_grant) && w_last_new;
        if (|w_grant) begin
          r_tdata <= w_grant[1] ? w_pack[1] : w_pack[0];
          r_ptr   <= w_grant[0];
        end
      end
    end
  end

  assign acknowledge_C0 = w_ack[0];
  assign acknowledge_C1 = w_ack[1];
  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tdata   = r_tdata;
  assign m_axis_tlast   = r_tlast;
  assign data_cnt       = r_data_cnt;
  assign tlast_cnt      = r_tlast_cnt;
  assign o_rx_done      = r_done;
endmodule

// File: tb/tb_paicore_recv_merge_2c.sv
// tb/tb_paicore_recv_merge_2c.sv - scoreboard bench for paicore_recv_merge_2c
module tb_paicore_recv_merge_2c;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_enable;
  logic [31:0] recv_len;
  logic [31:0] data_cnt;
  logic [31:0] tlast_cnt;
  logic        request_C0;
  logic [31:0] din_C0;
  logic        acknowledge_C0;
  logic        request_C1;
  logic [31:0] din_C1;
  logic        acknowledge_C1;
  logic        tready;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        rx_done;

  int total = 0;
  int bad = 0;
  int words_acked [2] = '{0, 0};
  int done_seen = 0;
  logic [64:0] sb [$];

  always #5 clk = ~clk;

  paicore_recv_merge_2c #(.SYNC_STAGES(2), .IDLE_TIMEOUT(16)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .rx_enable(rx_enable),
    .recv_len(recv_len), .data_cnt(data_cnt), .tlast_cnt(tlast_cnt),
    .request_C0(request_C0), .din_C0(din_C0), .acknowledge_C0(acknowledge_C0),
    .request_C1(request_C1), .din_C1(din_C1), .acknowledge_C1(acknowledge_C1),
    .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .o_rx_done(rx_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? acknowledge_C0 : acknowledge_C1;
  endfunction

  task automatic send(input int ch, input logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    if (ch == 0) begin din_C0 = d; request_C0 = 1'b1; end
    else begin din_C1 = d; request_C1 = 1'b1; end
    n = 0;
    while (ack_of(ch) == 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
    lat = n;
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL ack_rise_timeout ch%0d: no acknowledge after %0d cycles, required one", ch, n);
    end else words_acked[ch]++;
    @(negedge clk);
    if (ch == 0) request_C0 = 1'b0; else request_C1 = 1'b0;
    n = 0;
    while (ack_of(ch) == 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL ack_fall_timeout ch%0d: acknowledge still high after %0d cycles", ch, n);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin @(negedge clk); n++; end
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    logic        exp_done;
    logic        prev_stall;
    logic [64:0] prev_beat;
    logic [64:0] e;
    exp_done = 1'b0;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        exp_done = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (rx_done || exp_done) chk("rx_done_pulse", 64'(rx_done), 64'(exp_done));
        if (rx_done) done_seen++;
        if (tvalid && !tready && prev_stall) chk("stall_stable", {tlast, tdata}, prev_beat);
        prev_stall = tvalid && !tready;
        prev_beat = {tlast, tdata};
        exp_done = tvalid && tready && tlast;
        if (tvalid && tready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got %h last=%0b with empty scoreboard", tdata, tlast);
          end else begin
            e = sb.pop_front();
            chk("beat_tdata", tdata, e[63:0]);
            chk("beat_tlast", 64'(tlast), 64'(e[64]));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int m;
    logic seen;
    rst_n = 1'b0; rx_enable = 1'b1; recv_len = 32'd1; tready = 1'b1;
    request_C0 = 1'b0; request_C1 = 1'b0; din_C0 = '0; din_C1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_ack0", 64'(acknowledge_C0), 64'd0);
    chk("rst_ack1", 64'(acknowledge_C1), 64'd0);
    chk("rst_data_cnt", 64'(data_cnt), 64'd0);
    chk("rst_tlast_cnt", 64'(tlast_cnt), 64'd0);
    chk("rst_rx_done", 64'(rx_done), 64'd0);
    rst_n = 1'b1;

    // Single C0 pair, one-beat frames.
    sb.push_back({1'b1, 64'h22222222_11111111});
    send(0, 32'h11111111, lat); chk("t1_ack_latency_w0", 64'(lat), 64'd3);
    send(0, 32'h22222222, lat); chk("t1_ack_latency_w1", 64'(lat), 64'd3);
    drain("t1");
    chk("t1_data_cnt", 64'(data_cnt), 64'd1);
    chk("t1_tlast_cnt", 64'(tlast_cnt), 64'd1);
    chk("t1_done_pulses", 64'(done_seen), 64'd1);

    // Both channels concurrently, 4-beat frame, C0 wins first after reset.
    do_reset();
    recv_len = 32'd4;
    sb.push_back({1'b0, 64'hA0000001_A0000000});
    sb.push_back({1'b0, 64'hB0000001_B0000000});
    sb.push_back({1'b0, 64'hA0000003_A0000002});
    sb.push_back({1'b1, 64'hB0000003_B0000002});
    fork
      begin
        int l0;
        for (int i = 0; i < 4; i++) send(0, 32'hA0000000 + 32'(i), l0);
      end
      begin
        int l1;
        for (int j = 0; j < 4; j++) send(1, 32'hB0000000 + 32'(j), l1);
      end
    join
    drain("t2");
    chk("t2_data_cnt", 64'(data_cnt), 64'd4);
    chk("t2_tlast_cnt", 64'(tlast_cnt), 64'd1);

    // Back-pressure: output + pending hold 4 words, 5th ack withheld.
    recv_len = 32'd3;
    @(negedge clk);
    tready = 1'b0;
    words_acked[0] = 0;
    sb.push_back({1'b0, 64'h30000001_30000000});
    sb.push_back({1'b0, 64'h30000003_30000002});
    sb.push_back({1'b1, 64'h30000005_30000004});
    fork
      begin
        int l2;
        for (int k = 0; k < 6; k++) send(0, 32'h30000000 + 32'(k), l2);
      end
      begin
        repeat (50) @(negedge clk);
        chk("t3_acks_while_stalled", 64'(words_acked[0]), 64'd4);
        chk("t3_stall_tvalid", 64'(tvalid), 64'd1);
        chk("t3_stall_tdata", tdata, 64'h30000001_30000000);
        tready = 1'b1;
      end
    join
    drain("t3");
    chk("t3_data_cnt", 64'(data_cnt), 64'd7);
    chk("t3_tlast_cnt", 64'(tlast_cnt), 64'd2);

    // Idle flush of a lone C1 word, stream mode.
    recv_len = 32'd0;
    sb.push_back({1'b0, 64'h00000000_ABCD0123});
    fork
      send(1, 32'hABCD0123, lat);
      begin
        n = 0;
        while (!acknowledge_C1 && n < 100) begin @(posedge clk); #1; n++; end
        m = 0;
        while (!tvalid && m < 100) begin @(posedge clk); #1; m++; end
        chk("t4_flush_latency", 64'(m), 64'd17);
      end
    join
    drain("t4");
    chk("t4_tlast_cnt", 64'(tlast_cnt), 64'd2);

    // rx_enable gating.
    @(negedge clk);
    rx_enable = 1'b0;
    din_C0 = 32'h5555AAAA;
    request_C0 = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; seen = seen | acknowledge_C0; end
    chk("t5_ack_gated", 64'(seen), 64'd0);
    sb.push_back({1'b0, 64'h00000000_5555AAAA});
    @(negedge clk);
    rx_enable = 1'b1;
    @(posedge clk); #1;
    chk("t5_ack_after_enable", 64'(acknowledge_C0), 64'd1);
    @(negedge clk);
    request_C0 = 1'b0;
    drain("t5");

    // Reset mid-handshake with a stalled beat.
    do_reset();
    recv_len = 32'd3;
    sb.push_back({1'b0, 64'hC0000001_C0000000});
    send(1, 32'hC0000000, lat);
    send(1, 32'hC0000001, lat);
    drain("t6a");
    @(negedge clk);
    tready = 1'b0;
    send(1, 32'hC0000002, lat);
    send(1, 32'hC0000003, lat);
    @(negedge clk);
    din_C1 = 32'hC0000004;
    request_C1 = 1'b1;
    n = 0;
    while (!acknowledge_C1 && n < 100) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    chk("t6_pre_ack1", 64'(acknowledge_C1), 64'd1);
    chk("t6_pre_tvalid", 64'(tvalid), 64'd1);
    chk("t6_pre_data_cnt", 64'(data_cnt), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack1", 64'(acknowledge_C1), 64'd0);
    chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
    chk("t6_rst_data_cnt", 64'(data_cnt), 64'd0);
    chk("t6_rst_tlast_cnt", 64'(tlast_cnt), 64'd0);
    request_C1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    recv_len = 32'd2;
    tready = 1'b1;
    sb.push_back({1'b0, 64'hD0000001_D0000000});
    sb.push_back({1'b1, 64'hD0000003_D0000002});
    for (int i = 0; i < 4; i++) send(0, 32'hD0000000 + 32'(i), lat);
    drain("t6b");
    chk("t6_data_cnt", 64'(data_cnt), 64'd2);
    chk("t6_tlast_cnt", 64'(tlast_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
